operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Initiator side of the 64x16 register file. It owns the file's shared write/read-A port and its read-B port. The block accepts decoded instructions, reads both source operands and presents them to execute through a registered valid/ready stage. It takes writebacks from execute, drives them into the file, and keeps a per-register busy scoreboard so no operand is read while a write to it is still pending.

Parameters:
DATA_WIDTH, 16, register/operand width
ADDR_WIDTH, 6, register address width; scoreboard depth is 2**ADDR_WIDTH (64)

Ports:
Clock  in  1  rising-edge clock
nReset  in  1  asynchronous, active-low reset
InValid  in  1  decoded instruction available
InReady  out  1  instruction accepted this cycle when InValid && InReady
InSrcA  in  6  source A register
InSrcB  in  6  source B register
InUseB  in  1  source B is a real operand (its busy bit is checked)
InDest  in  6  destination register
InDestWe  in  1  instruction will write InDest later
WbValid  in  1  writeback this cycle; always accepted
WbAddr  in  6  writeback register
WbData  in  16  writeback value
RfWriteEnable  out  1  to register file WriteEnable
RfAddressA  out  6  to register file AddressA (shared write/read-A address)
RfWriteData  out  16  to register file WriteData
RfReadDataA  in  16  from register file ReadDataA (asynchronous)
RfAddressB  out  6  to register file AddressB
RfReadDataB  in  16  from register file ReadDataB (asynchronous)
OutValid  out  1  operand bundle valid
OutReady  in  1  execute accepts bundle
OutDataA  out  16  operand A
OutDataB  out  16  operand B
OutDest  out  6  destination passed through
OutDestWe  out  1  write flag passed through
BusyCount  out  7  number of set busy bits (0..64)
StallCount  out  16  cycles with InValid && !InReady; saturates at 0xFFFF
WbOrphan  out  1  sticky: a writeback arrived for a register that was not busy

Behaviour:
- Reset (async assert, sync-release use): clear the busy vector; OutValid=0; OutDataA/B=0; OutDest=0; OutDestWe=0; BusyCount=0; StallCount=0; WbOrphan=0. Register file contents are not reset.
- Port muxing is combinational:
  - RfWriteEnable=WbValid; RfWriteData=WbData.
  - RfAddressA = WbValid ? WbAddr : InSrcA.
  - RfAddressB = InSrcB at all times.
- Slot free: slot_free = !OutValid || OutReady.
- InReady (combinational) = !WbValid && slot_free && !busy[InSrcA] && !(InUseB && busy[InSrcB]) && !(InDestWe && busy[InDest]).
  - A writeback owns port A, so it blocks issue that cycle.
  - A pending write to the destination also stalls issue (WAW hazard).
- Issue (InValid && InReady), latency 1: on that edge, capture OutDataA=RfReadDataA, OutDataB=RfReadDataB, OutDest=InDest, OutDestWe=InDestWe, and set OutValid=1. If InDestWe, set busy[InDest].
- Output hold: while OutValid && !OutReady, all Out* signals stay stable. On OutReady with no new issue, OutValid goes to 0. Back-to-back issue with OutReady=1 sustains one bundle per cycle.
- Writeback, 1 cycle: the file writes on the edge. If busy[WbAddr], clear it; otherwise set WbOrphan (sticky until reset). The write happens in both cases.
- Simultaneous set and clear: issue never coincides with a writeback, because InReady=0 whenever WbValid=1. The busy vector therefore sees at most one update per cycle.
- Read-after-writeback: a source cleared by a writeback at edge N is readable at edge N+1 with the new value. No bypass path exists.
- BusyCount is a registered popcount, updated together with the busy vector: +1 on a set, -1 on a non-orphan clear.
- StallCount increments on each cycle with InValid && !InReady and holds at 0xFFFF.
- Register 0 has no special meaning; it is scoreboarded like any other register.

Test Plan:
- Reset then issue InSrcA=3, InSrcB=5, InUseB=1, InDestWe=0 with regs[3]=0x1234 and regs[5]=0xABCD, OutReady=1 -> the next cycle shows OutValid=1, OutDataA=0x1234, OutDataB=0xABCD; BusyCount stays 0.
- Issue InDest=7, InDestWe=1, then issue a second instruction with InSrcA=7 -> InReady=0 and StallCount counts up. Then WbValid with WbAddr=7, WbData=0x00FF -> the next cycle InReady=1, the issue yields OutDataA=0x00FF, and BusyCount returns 0.
- WbValid=1 while InValid=1 and no hazard -> InReady=0 that cycle, RfAddressA=WbAddr; the issue proceeds the next cycle.
- Hold OutReady=0 with OutValid=1 -> InReady=0 and Out* signals stay stable. Raise OutReady -> the pending instruction issues on that edge.
- Writeback to non-busy register 9 -> the write occurs, WbOrphan=1 and stays set; BusyCount unchanged.
- Set busy on registers 1,2,3, then assert nReset low mid-stream -> BusyCount=0, OutValid=0, WbOrphan=0 immediately; after release, InSrcA=2 issues without a stall.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: owns the register-file ports, scoreboards pending writes per register
// and hands both source operands to execute through a registered valid/ready slot.
module operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [ADDR_WIDTH-1:0] InSrcA,
  input  logic [ADDR_WIDTH-1:0] InSrcB,
  input  logic                  InUseB,
  input  logic [ADDR_WIDTH-1:0] InDest,
  input  logic                  InDestWe,
  input  logic                  WbValid,
  input  logic [ADDR_WIDTH-1:0] WbAddr,
  input  logic [DATA_WIDTH-1:0] WbData,
  output logic                  RfWriteEnable,
  output logic [ADDR_WIDTH-1:0] RfAddressA,
  output logic [DATA_WIDTH-1:0] RfWriteData,
  input  logic [DATA_WIDTH-1:0] RfReadDataA,
  output logic [ADDR_WIDTH-1:0] RfAddressB,
  input  logic [DATA_WIDTH-1:0] RfReadDataB,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutDataA,
  output logic [DATA_WIDTH-1:0] OutDataB,
  output logic [ADDR_WIDTH-1:0] OutDest,
  output logic                  OutDestWe,
  output logic [ADDR_WIDTH:0]   BusyCount,
  output logic [15:0]           StallCount,
  output logic                  WbOrphan
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
  logic [15:0]           stall_count_q, stall_count_d;
  logic                  wb_orphan_q, wb_orphan_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_a_q, out_data_a_d;
  logic [DATA_WIDTH-1:0] out_data_b_q, out_data_b_d;
  logic [ADDR_WIDTH-1:0] out_dest_q, out_dest_d;
  logic                  out_dest_we_q, out_dest_we_d;
  logic                  slot_free_s, in_ready_s, issue_s;

  // A writeback owns the shared address port, so it always wins port A.
  assign RfWriteEnable = WbValid;
  assign RfWriteData   = WbData;
  assign RfAddressA    = WbValid ? WbAddr : InSrcA;
  assign RfAddressB    = InSrcB;

  assign slot_free_s = !out_valid_q || OutReady;
  assign in_ready_s  = !WbValid && slot_free_s && !busy_q[InSrcA]
                       && !(InUseB && busy_q[InSrcB])
                       && !(InDestWe && busy_q[InDest]);
  assign issue_s     = InValid && in_ready_s;

  // Scoreboard update; issue and writeback are mutually exclusive, so one change per cycle.
  always_comb begin
    busy_d       = busy_q;
    busy_count_d = busy_count_q;
    wb_orphan_d  = wb_orphan_q;
    if (WbValid) begin
      if (busy_q[WbAddr]) begin
        busy_d[WbAddr] = 1'b0;
        busy_count_d   = busy_count_q - COUNT_ONE;
      end else begin
        wb_orphan_d = 1'b1;
      end
    end else if (issue_s && InDestWe) begin
      busy_d[InDest] = 1'b1;
      busy_count_d   = busy_count_q + COUNT_ONE;
    end else begin
      busy_d = busy_q;
    end
  end

  // Stall counter saturates instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (InValid && !in_ready_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Output slot: capture on issue, drop on accept, otherwise hold.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_a_d  = out_data_a_q;
    out_data_b_d  = out_data_b_q;
    out_dest_d    = out_dest_q;
    out_dest_we_d = out_dest_we_q;
    if (issue_s) begin
      out_valid_d   = 1'b1;
      out_data_a_d  = RfReadDataA;
      out_data_b_d  = RfReadDataB;
      out_dest_d    = InDest;
      out_dest_we_d = InDestWe;
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      busy_q        <= '0;
      busy_count_q  <= '0;
      stall_count_q <= 16'h0000;
      wb_orphan_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_a_q  <= '0;
      out_data_b_q  <= '0;
      out_dest_q    <= '0;
      out_dest_we_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      busy_count_q  <= busy_count_d;
      stall_count_q <= stall_count_d;
      wb_orphan_q   <= wb_orphan_d;
      out_valid_q   <= out_valid_d;
      out_data_a_q  <= out_data_a_d;
      out_data_b_q  <= out_data_b_d;
      out_dest_q    <= out_dest_d;
      out_dest_we_q <= out_dest_we_d;
    end
  end

  assign InReady    = in_ready_s;
  assign OutValid   = out_valid_q;
  assign OutDataA   = out_data_a_q;
  assign OutDataB   = out_data_b_q;
  assign OutDest    = out_dest_q;
  assign OutDestWe  = out_dest_we_q;
  assign BusyCount  = busy_count_q;
  assign StallCount = stall_count_q;
  assign WbOrphan   = wb_orphan_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: models the 64x16 register file around the DUT and checks it
// against a register/scoreboard reference model built from the stage's rules.
module tb_operand_fetch;

  logic        Clock, nReset;
  logic        InValid, InReady, InUseB, InDestWe;
  logic [5:0]  InSrcA, InSrcB, InDest;
  logic        WbValid;
  logic [5:0]  WbAddr;
  logic [15:0] WbData;
  logic        RfWriteEnable;
  logic [5:0]  RfAddressA, RfAddressB;
  logic [15:0] RfWriteData, RfReadDataA, RfReadDataB;
  logic        OutValid, OutReady, OutDestWe;
  logic [15:0] OutDataA, OutDataB;
  logic [5:0]  OutDest;
  logic [6:0]  BusyCount;
  logic [15:0] StallCount;
  logic        WbOrphan;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch dut (
    .Clock(Clock), .nReset(nReset),
    .InValid(InValid), .InReady(InReady), .InSrcA(InSrcA), .InSrcB(InSrcB),
    .InUseB(InUseB), .InDest(InDest), .InDestWe(InDestWe),
    .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
    .RfWriteEnable(RfWriteEnable), .RfAddressA(RfAddressA), .RfWriteData(RfWriteData),
    .RfReadDataA(RfReadDataA), .RfAddressB(RfAddressB), .RfReadDataB(RfReadDataB),
    .OutValid(OutValid), .OutReady(OutReady), .OutDataA(OutDataA), .OutDataB(OutDataB),
    .OutDest(OutDest), .OutDestWe(OutDestWe),
    .BusyCount(BusyCount), .StallCount(StallCount), .WbOrphan(WbOrphan)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register file environment (asynchronous read, synchronous write, backdoor preload).
  logic [15:0] rf [64];
  logic        preload_en;
  logic [5:0]  preload_addr;
  logic [15:0] preload_data;
  always @(posedge Clock) begin
    if (preload_en) rf[preload_addr] <= preload_data;
    else if (RfWriteEnable) rf[RfAddressA] <= RfWriteData;
  end
  assign RfReadDataA = rf[RfAddressA];
  assign RfReadDataB = rf[RfAddressB];

  // Reference model state
  bit [15:0] m_regs [64];
  bit        m_busy [64];
  bit        m_ov, m_we, m_orphan;
  bit [15:0] m_a, m_b;
  bit [5:0]  m_dest;
  int        m_stall;

  function automatic int m_count();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit exp_ready();
    if (WbValid) return 1'b0;
    if (m_ov && !OutReady) return 1'b0;
    if (m_busy[InSrcA]) return 1'b0;
    if (InUseB && m_busy[InSrcB]) return 1'b0;
    if (InDestWe && m_busy[InDest]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ov = 0; m_we = 0; m_orphan = 0; m_a = 0; m_b = 0; m_dest = 0; m_stall = 0;
  endtask

  task automatic model_step();
    bit r;
    r = exp_ready();
    if (InValid && !r && m_stall < 65535) m_stall++;
    if (InValid && r) begin
      m_a = m_regs[InSrcA]; m_b = m_regs[InSrcB];
      m_dest = InDest; m_we = InDestWe; m_ov = 1'b1;
      if (InDestWe) m_busy[InDest] = 1'b1;
    end else if (OutReady) begin
      m_ov = 1'b0;
    end
    if (WbValid) begin
      if (m_busy[WbAddr]) m_busy[WbAddr] = 1'b0;
      else m_orphan = 1'b1;
      m_regs[WbAddr] = WbData;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_instr(input bit v, input bit [5:0] a, input bit [5:0] b, input bit ub,
                           input bit [5:0] d, input bit we);
    InValid = v; InSrcA = a; InSrcB = b; InUseB = ub; InDest = d; InDestWe = we;
  endtask

  task automatic test_reset();
    nReset = 1'b0; InValid = 0; InSrcA = 0; InSrcB = 0; InUseB = 0; InDest = 0; InDestWe = 0;
    WbValid = 0; WbAddr = 0; WbData = 0; OutReady = 1'b1;
    preload_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      preload_addr = 6'(i);
      preload_data = (i == 3) ? 16'h1234 : (i == 5) ? 16'hABCD : ((16'(i) * 16'h0111) ^ 16'h5A5A);
      m_regs[i] = preload_data;
      @(posedge Clock); #1;
    end
    preload_en = 1'b0;
    model_reset();
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %0b want 0", OutValid); end
    n_checks++; if (OutDataA !== 16'h0 || OutDataB !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h/%h want 0/0", OutDataA, OutDataB); end
    n_checks++; if (BusyCount !== 7'd0 || StallCount !== 16'd0 || WbOrphan !== 1'b0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d/%0b want 0/0/0", BusyCount, StallCount, WbOrphan); end
    n_checks++; if (OutDest !== 6'd0 || OutDestWe !== 1'b0) begin n_fail++; $display("FAIL reset_dest got %0d/%0b want 0/0", OutDest, OutDestWe); end
    nReset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_basic_issue();
    set_instr(1, 6'd3, 6'd5, 1, 6'd0, 0); OutReady = 1'b1;
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL basic_inready got %0b want 1", InReady); end
    tick();
    InValid = 0;
    n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL basic_outvalid got %0b want 1", OutValid); end
    n_checks++; if (OutDataA !== 16'h1234 || OutDataB !== 16'hABCD) begin n_fail++; $display("FAIL basic_data got %h/%h want 1234/abcd", OutDataA, OutDataB); end
    n_checks++; if (BusyCount !== 7'd0) begin n_fail++; $display("FAIL basic_busy got %0d want 0", BusyCount); end
    tick();
    n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %0b want 0", OutValid); end
  endtask

  task automatic test_raw_hazard();
    set_instr(1, 6'd0, 6'd0, 0, 6'd7, 1);
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL raw_first_ready got %0b want 1", InReady); end
    tick();
    n_checks++; if (BusyCount !== 7'd1) begin n_fail++; $display("FAIL raw_busy_set got %0d want 1", BusyCount); end
    set_instr(1, 6'd7, 6'd0, 0, 6'd8, 0);
    #1;
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready got %0b want 0", InReady); end
    tick(); tick(); tick();
    n_checks++; if (StallCount !== 16'd3) begin n_fail++; $display("FAIL raw_stallcount got %0d want 3", StallCount); end
    WbValid = 1; WbAddr = 6'd7; WbData = 16'h00FF;
    #1;
    n_checks++; if (InReady !== 1'b0 || RfAddressA !== 6'd7) begin n_fail++; $display("FAIL raw_wb_port got ready %0b addr %0d want 0/7", InReady, RfAddressA); end
    tick();
    WbValid = 0;
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb_ready got %0b want 1", InReady); end
    tick();
    InValid = 0;
    n_checks++; if (OutDataA !== 16'h00FF || OutValid !== 1'b1) begin n_fail++; $display("FAIL raw_readback got %h/%0b want 00ff/1", OutDataA, OutValid); end
    n_checks++; if (BusyCount !== 7'd0 || StallCount !== 16'd4) begin n_fail++; $display("FAIL raw_counts got %0d/%0d want 0/4", BusyCount, StallCount); end
    tick();
  endtask

  task automatic test_wb_priority_orphan();
    set_instr(1, 6'd9, 6'd5, 1, 6'd0, 0);
    WbValid = 1; WbAddr = 6'd9; WbData = 16'h9999;
    #1;
    n_checks++; if (InReady !== 1'b0 || RfAddressA !== 6'd9 || RfWriteEnable !== 1'b1) begin n_fail++; $display("FAIL wbprio_port got ready %0b addr %0d we %0b want 0/9/1", InReady, RfAddressA, RfWriteEnable); end
    tick();
    WbValid = 0;
    n_checks++; if (WbOrphan !== 1'b1 || BusyCount !== 7'd0) begin n_fail++; $display("FAIL orphan_set got %0b/%0d want 1/0", WbOrphan, BusyCount); end
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL wbprio_next_ready got %0b want 1", InReady); end
    tick();
    InValid = 0;
    n_checks++; if (OutDataA !== 16'h9999 || OutDataB !== 16'hABCD) begin n_fail++; $display("FAIL wbprio_data got %h/%h want 9999/abcd", OutDataA, OutDataB); end
    tick(); tick();
    n_checks++; if (WbOrphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky got %0b want 1", WbOrphan); end
  endtask

  task automatic test_back_to_back();
    OutReady = 1; set_instr(1, 6'd3, 6'd5, 1, 6'd10, 0);
    tick();
    OutReady = 0; set_instr(1, 6'd5, 6'd3, 1, 6'd11, 0);
    #1;
    n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %0b want 0", InReady); end
    tick(); tick();
    n_checks++; if (OutValid !== 1'b1 || OutDataA !== 16'h1234 || OutDataB !== 16'hABCD || OutDest !== 6'd10) begin n_fail++; $display("FAIL hold_stable got %0b %h %h %0d want 1 1234 abcd 10", OutValid, OutDataA, OutDataB, OutDest); end
    OutReady = 1;
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL release_ready got %0b want 1", InReady); end
    tick();
    n_checks++; if (OutDataA !== 16'hABCD || OutDest !== 6'd11) begin n_fail++; $display("FAIL release_issue got %h/%0d want abcd/11", OutDataA, OutDest); end
    set_instr(1, 6'd9, 6'd3, 1, 6'd12, 0);
    tick();
    InValid = 0;
    n_checks++; if (OutValid !== 1'b1 || OutDataA !== 16'h9999 || OutDest !== 6'd12) begin n_fail++; $display("FAIL b2b got %0b %h %0d want 1 9999 12", OutValid, OutDataA, OutDest); end
    tick();
  endtask

  task automatic test_reset_midstream();
    set_instr(1, 6'd0, 6'd0, 0, 6'd1, 1); tick();
    InDest = 6'd2; tick();
    InDest = 6'd3; tick();
    InValid = 0;
    n_checks++; if (BusyCount !== 7'd3) begin n_fail++; $display("FAIL mid_busy got %0d want 3", BusyCount); end
    #2 nReset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (BusyCount !== 7'd0 || OutValid !== 1'b0 || WbOrphan !== 1'b0 || StallCount !== 16'd0) begin n_fail++; $display("FAIL mid_reset got %0d/%0b/%0b/%0d want 0/0/0/0", BusyCount, OutValid, WbOrphan, StallCount); end
    @(posedge Clock); #1;
    nReset = 1'b1;
    set_instr(1, 6'd2, 6'd0, 0, 6'd0, 0);
    #1;
    n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready got %0b want 1", InReady); end
    tick();
    InValid = 0;
    n_checks++; if (OutDataA !== m_regs[2]) begin n_fail++; $display("FAIL mid_release_data got %h want %h", OutDataA, m_regs[2]); end
    tick();
  endtask

  task automatic test_random();
    int pick;
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_instr(($urandom % 3) != 0, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                $urandom % 2 == 1, 6'($urandom_range(0, 7)), $urandom % 2 == 1);
      OutReady = ($urandom % 4) != 0;
      WbValid = ($urandom % 4) == 0;
      WbData = 16'($urandom);
      WbAddr = 6'($urandom_range(0, 7));
      if (m_count() > 0 && ($urandom % 5) != 0) begin
        pick = $urandom_range(1, m_count());
        for (int r = 0; r < 64; r++) begin
          if (m_busy[r]) begin
            pick--;
            if (pick == 0) WbAddr = 6'(r);
          end
        end
      end
      #1;
      n_checks++; if (InReady !== exp_ready()) begin n_fail++; $display("FAIL rand_inready cyc %0d got %0b want %0b", cyc, InReady, exp_ready()); end
      n_checks++; if (RfAddressA !== (WbValid ? WbAddr : InSrcA)) begin n_fail++; $display("FAIL rand_rfaddra cyc %0d got %0d", cyc, RfAddressA); end
      tick();
      n_checks++; if (OutValid !== m_ov) begin n_fail++; $display("FAIL rand_outvalid cyc %0d got %0b want %0b", cyc, OutValid, m_ov); end
      if (m_ov) begin
        n_checks++; if (OutDataA !== m_a || OutDataB !== m_b || OutDest !== m_dest || OutDestWe !== m_we) begin n_fail++; $display("FAIL rand_bundle cyc %0d got %h %h %0d %0b want %h %h %0d %0b", cyc, OutDataA, OutDataB, OutDest, OutDestWe, m_a, m_b, m_dest, m_we); end
      end
      n_checks++; if (BusyCount !== 7'(m_count()) || StallCount !== 16'(m_stall) || WbOrphan !== m_orphan) begin n_fail++; $display("FAIL rand_counters cyc %0d got %0d/%0d/%0b want %0d/%0d/%0b", cyc, BusyCount, StallCount, WbOrphan, m_count(), m_stall, m_orphan); end
    end
    WbValid = 0; InValid = 0; OutReady = 1;
    tick();
  endtask

  task automatic test_stall_saturate();
    nReset = 1'b0; #1; model_reset();
    @(posedge Clock); #1; nReset = 1'b1;
    set_instr(1, 6'd21, 6'd0, 0, 6'd20, 1);
    tick();
    set_instr(1, 6'd20, 6'd0, 0, 6'd22, 0);
    for (int i = 0; i < 65540; i++) tick();
    n_checks++; if (StallCount !== 16'hFFFF || m_stall != 65535) begin n_fail++; $display("FAIL stall_saturate got %h want ffff", StallCount); end
    InValid = 0;
    tick();
    n_checks++; if (StallCount !== 16'hFFFF) begin n_fail++; $display("FAIL stall_hold got %h want ffff", StallCount); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_raw_hazard();
    test_wb_priority_orphan();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    test_stall_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
